// File: rtl/uart.sv
// UART with register interface: 8N1 TX/RX, programmable bit divisor, and
// small TX/RX FIFOs with sticky error flags and an RX-not-empty interrupt.
module uart #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        UART_WE,
  input  logic        UART_RE,
  input  logic [1:0]  UART_A,
  input  logic [31:0] UART_WD,
  output logic [31:0] UART_RD,
  input  logic        RXD,
  output logic        TXD,
  output logic        UART_INT
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST  = 16'(CLK_DIV);

  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
  localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3,
                         RX_BREAK = 3'd4;

  logic [15:0]   r_div;
  logic          r_rx_ie, r_rx_ovr, r_frame_err, r_tx_ovf;
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [AW:0]   r_tx_cnt, r_rx_cnt;
  logic [1:0]    r_tx_state;
  logic [15:0]   r_tx_tmr;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_sh;
  logic          r_txd;
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [2:0]    r_rx_state;
  logic [15:0]   r_rx_tmr;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;

  logic w_wr_data, w_wr_stat, w_tx_full, w_tx_nempty, w_tx_tick, w_tx_pop, w_tx_push;
  logic w_tx_ovf_set, w_tx_busy, w_rx_full, w_rx_nempty, w_rx_tick, w_rx_stop_ok;
  logic w_rx_pop, w_rx_push, w_rx_ovr_set, w_ferr_set, w_unused_wd;
  logic [15:0] w_div_m1, w_div_half;

  assign w_wr_data    = UART_WE && (UART_A == 2'd0);
  assign w_wr_stat    = UART_WE && (UART_A == 2'd1);
  assign w_div_m1     = r_div - 16'd1;
  assign w_div_half   = {1'b0, r_div[15:1]} - 16'd1;
  assign w_unused_wd  = &{1'b0, UART_WD[31:16]};

  assign w_tx_full    = (r_tx_cnt == FULL_CNT);
  assign w_tx_nempty  = (r_tx_cnt != '0);
  assign w_tx_tick    = (r_tx_tmr == 16'd0);
  assign w_tx_pop     = w_tx_nempty && ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_tick));
  assign w_tx_push    = w_wr_data && (!w_tx_full || w_tx_pop);
  assign w_tx_ovf_set = w_wr_data && w_tx_full && !w_tx_pop;
  assign w_tx_busy    = w_tx_nempty || (r_tx_state != TX_IDLE);

  assign w_rx_full    = (r_rx_cnt == FULL_CNT);
  assign w_rx_nempty  = (r_rx_cnt != '0);
  assign w_rx_tick    = (r_rx_tmr == 16'd0);
  assign w_rx_stop_ok = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_s2;
  assign w_ferr_set   = (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_s2;
  assign w_rx_pop     = UART_RE && (UART_A == 2'd0) && w_rx_nempty;
  assign w_rx_push    = w_rx_stop_ok && (!w_rx_full || w_rx_pop);
  assign w_rx_ovr_set = w_rx_stop_ok && w_rx_full && !w_rx_pop;

  // Sticky flags: a same-cycle set event wins over a write-1-to-clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div       <= DIV_RST;
      r_rx_ie     <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_ovf    <= 1'b0;
    end else begin
      if (UART_WE && (UART_A == 2'd2))
        r_div <= (UART_WD[15:0] < 16'd4) ? 16'd4 : UART_WD[15:0];
      if (UART_WE && (UART_A == 2'd3))
        r_rx_ie <= UART_WD[0];
      r_rx_ovr    <= w_rx_ovr_set | (r_rx_ovr    & ~(w_wr_stat & UART_WD[3]));
      r_frame_err <= w_ferr_set   | (r_frame_err & ~(w_wr_stat & UART_WD[4]));
      r_tx_ovf    <= w_tx_ovf_set | (r_tx_ovf    & ~(w_wr_stat & UART_WD[5]));
    end
  end

  always_ff @(posedge CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= UART_WD[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + (AW+1)'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - (AW+1)'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + (AW+1)'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - (AW+1)'(1);
    end
  end

  // TXD is registered and updated together with each state change.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tx_state <= TX_IDLE;
      r_tx_tmr   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_txd <= 1'b1;
          if (w_tx_pop) begin
            r_tx_state <= TX_START;
            r_tx_sh    <= r_tx_mem[r_tx_rp];
            r_tx_tmr   <= w_div_m1;
            r_txd      <= 1'b0;
          end
        end
        TX_START: begin
          if (w_tx_tick) begin
            r_tx_state <= TX_DATA;
            r_tx_bit   <= 3'd0;
            r_tx_tmr   <= w_div_m1;
            r_txd      <= r_tx_sh[0];
          end else r_tx_tmr <= r_tx_tmr - 16'd1;
        end
        TX_DATA: begin
          if (w_tx_tick) begin
            r_tx_tmr <= w_div_m1;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= TX_STOP;
              r_txd      <= 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              r_tx_sh  <= r_tx_sh >> 1;
              r_txd    <= r_tx_sh[1];
            end
          end else r_tx_tmr <= r_tx_tmr - 16'd1;
        end
        default: begin
          if (w_tx_tick) begin
            if (w_tx_pop) begin
              r_tx_state <= TX_START;
              r_tx_sh    <= r_tx_mem[r_tx_rp];
              r_tx_tmr   <= w_div_m1;
              r_txd      <= 1'b0;
            end else r_tx_state <= TX_IDLE;
          end else r_tx_tmr <= r_tx_tmr - 16'd1;
        end
      endcase
    end
  end

  // After a framing error the receiver parks in BREAK until the line returns high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_tmr   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
    end else begin
      r_rx_s1   <= RXD;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_state <= RX_START;
            r_rx_tmr   <= w_div_half;
          end
        end
        RX_START: begin
          if (w_rx_tick) begin
            if (r_rx_s2) r_rx_state <= RX_IDLE;
            else begin
              r_rx_state <= RX_DATA;
              r_rx_bit   <= 3'd0;
              r_rx_tmr   <= w_div_m1;
            end
          end else r_rx_tmr <= r_rx_tmr - 16'd1;
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_tmr <= w_div_m1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else r_rx_bit <= r_rx_bit + 3'd1;
          end else r_rx_tmr <= r_rx_tmr - 16'd1;
        end
        RX_STOP: begin
          if (w_rx_tick) r_rx_state <= r_rx_s2 ? RX_IDLE : RX_BREAK;
          else r_rx_tmr <= r_rx_tmr - 16'd1;
        end
        default: begin
          if (r_rx_s2) r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    UART_RD = '0;
    case (UART_A)
      2'd0:    if (w_rx_nempty) UART_RD = {24'b0, r_rx_mem[r_rx_rp]};
      2'd1:    UART_RD = {26'b0, r_tx_ovf, r_frame_err, r_rx_ovr, w_tx_busy, w_tx_full, w_rx_nempty};
      2'd2:    UART_RD = {16'b0, r_div};
      default: UART_RD = {31'b0, r_rx_ie};
    endcase
  end

  assign TXD      = r_txd;
  assign UART_INT = r_rx_ie & w_rx_nempty;
endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: directed steps with random bytes, compared
// against a queue-based model of the FIFOs, flags and serial frame format.
module tb_uart;
  localparam int          BITLEN  = 8;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] RST_DIV = 32'd434;

  logic        CLK = 1'b0;
  logic        RESET, UART_WE, UART_RE, RXD;
  logic [1:0]  UART_A;
  logic [31:0] UART_WD, UART_RD;
  logic        TXD, UART_INT;

  int total = 0;
  int bad   = 0;

  logic [7:0] mRxQ[$];
  logic [7:0] mTxQ[$];
  logic [7:0] txStream[$];
  bit         mOvr, mFerr, mTxOvf;

  always #5 CLK = ~CLK;

  uart #(.CLK_DIV(434), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .UART_WE(UART_WE), .UART_RE(UART_RE),
    .UART_A(UART_A), .UART_WD(UART_WD), .UART_RD(UART_RD),
    .RXD(RXD), .TXD(TXD), .UART_INT(UART_INT)
  );

  // Line level of an 8N1 frame at bit slot k: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frameBit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic [31:0] expStatus(input bit busy, input bit full);
    return {26'b0, mTxOvf, mFerr, mOvr, busy, full, (mRxQ.size() != 0)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    UART_A  = a;
    UART_WD = d;
    UART_WE = 1'b1;
    tick();
    UART_WE = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    UART_A = a;
    #1;
    d = UART_RD;
  endtask

  task automatic popData(output logic [31:0] d);
    UART_A  = 2'd0;
    UART_RE = 1'b1;
    #1;
    d = UART_RD;
    tick();
    UART_RE = 1'b0;
  endtask

  // Drives one frame on RXD and applies the receive rules to the model.
  task automatic rxFrame(input logic [7:0] b, input logic stopVal);
    for (int k = 0; k < 10; k++) begin
      RXD = (k == 9) ? stopVal : frameBit(b, k);
      repeat (BITLEN) tick();
    end
    RXD = 1'b1;
    repeat (4) tick();
    if (!stopVal) mFerr = 1'b1;
    else if (mRxQ.size() < DEPTH) mRxQ.push_back(b);
    else mOvr = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    logic [7:0]  txBytes[2];
    int          idx;

    RESET = 1'b1; UART_WE = 1'b0; UART_RE = 1'b0; UART_A = 2'd0; UART_WD = '0; RXD = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    $display("[TB] reset state");
    readReg(2'd1, rd); checkOutput("rst_status", rd, 32'h0);
    readReg(2'd2, rd); checkOutput("rst_div", rd, RST_DIV);
    readReg(2'd3, rd); checkOutput("rst_ctrl", rd, 32'h0);
    readReg(2'd0, rd); checkOutput("rst_data_empty", rd, 32'h0);
    checkOutput("rst_txd", 32'(TXD), 32'h1);
    checkOutput("rst_int", 32'(UART_INT), 32'h0);

    applyStimulus(2'd2, 32'(BITLEN));
    readReg(2'd2, rd); checkOutput("div_set", rd, 32'(BITLEN));

    $display("[TB] single TX frames");
    txBytes[0] = 8'h55;
    txBytes[1] = 8'($urandom);
    for (int t = 0; t < 2; t++) begin
      b = txBytes[t];
      applyStimulus(2'd0, {24'b0, b});
      checkOutput("tx_idle_latency", 32'(TXD), 32'h1);
      for (int i = 0; i < 10 * BITLEN; i++) begin
        tick();
        checkOutput($sformatf("tx_%02h_c%0d", b, i), 32'(TXD), 32'(frameBit(b, i / BITLEN)));
        if (i == 20) begin
          readReg(2'd1, rd); checkOutput("tx_busy", rd, expStatus(1'b1, 1'b0));
        end
      end
      tick();
      readReg(2'd1, rd); checkOutput("tx_done_status", rd, expStatus(1'b0, 1'b0));
    end

    $display("[TB] RX frames and interrupt");
    applyStimulus(2'd3, 32'h1);
    rxFrame(8'hA3, 1'b1);
    readReg(2'd1, rd); checkOutput("rx_status", rd, expStatus(1'b0, 1'b0));
    checkOutput("rx_int_set", 32'(UART_INT), 32'h1);
    popData(rd); checkOutput("rx_data_a3", rd, {24'b0, mRxQ.pop_front()});
    readReg(2'd1, rd); checkOutput("rx_status_popped", rd, expStatus(1'b0, 1'b0));
    checkOutput("rx_int_clr", 32'(UART_INT), 32'h0);
    rxFrame(8'($urandom), 1'b1);
    popData(rd); checkOutput("rx_data_rand", rd, {24'b0, mRxQ.pop_front()});

    $display("[TB] RX overrun");
    for (int j = 0; j < 5; j++) rxFrame(8'($urandom), 1'b1);
    readReg(2'd1, rd); checkOutput("rx_ovr_status", rd, expStatus(1'b0, 1'b0));
    applyStimulus(2'd1, 32'h08);
    mOvr = 1'b0;
    readReg(2'd1, rd); checkOutput("rx_ovr_cleared", rd, expStatus(1'b0, 1'b0));
    for (int j = 0; j < DEPTH; j++) begin
      popData(rd); checkOutput($sformatf("rx_order_%0d", j), rd, {24'b0, mRxQ.pop_front()});
    end
    popData(rd); checkOutput("rx_empty_read", rd, 32'h0);
    readReg(2'd1, rd); checkOutput("rx_empty_status", rd, expStatus(1'b0, 1'b0));

    $display("[TB] framing error and glitch");
    rxFrame(8'($urandom), 1'b0);
    readReg(2'd1, rd); checkOutput("ferr_status", rd, expStatus(1'b0, 1'b0));
    RXD = 1'b0;
    repeat (3) tick();
    RXD = 1'b1;
    repeat (20) tick();
    readReg(2'd1, rd); checkOutput("glitch_status", rd, expStatus(1'b0, 1'b0));
    applyStimulus(2'd1, 32'h10);
    mFerr = 1'b0;
    readReg(2'd1, rd); checkOutput("ferr_cleared", rd, expStatus(1'b0, 1'b0));

    $display("[TB] TX overflow and back-to-back frames");
    b = 8'($urandom);
    txStream.delete();
    txStream.push_back(b);
    applyStimulus(2'd0, {24'b0, b});
    tick(); tick();
    for (int j = 0; j < 5; j++) begin
      b = 8'($urandom);
      applyStimulus(2'd0, {24'b0, b});
      if (mTxQ.size() < DEPTH) mTxQ.push_back(b);
      else mTxOvf = 1'b1;
    end
    readReg(2'd1, rd); checkOutput("tx_ovf_status", rd, expStatus(1'b1, mTxQ.size() == DEPTH));
    while (mTxQ.size() != 0) txStream.push_back(mTxQ.pop_front());
    for (int n = 8; n <= 10 * BITLEN * txStream.size(); n++) begin
      tick();
      idx = n - 1;
      checkOutput($sformatf("b2b_c%0d", idx), 32'(TXD),
                  32'(frameBit(txStream[idx / (10 * BITLEN)], (idx % (10 * BITLEN)) / BITLEN)));
    end
    tick();
    checkOutput("b2b_idle_txd", 32'(TXD), 32'h1);
    readReg(2'd1, rd); checkOutput("b2b_done_status", rd, expStatus(1'b0, 1'b0));
    applyStimulus(2'd1, 32'h20);
    mTxOvf = 1'b0;
    readReg(2'd1, rd); checkOutput("tx_ovf_cleared", rd, expStatus(1'b0, 1'b0));

    $display("[TB] DIV clamp and mid-frame reset");
    applyStimulus(2'd2, 32'h2);
    readReg(2'd2, rd); checkOutput("div_clamp_2", rd, 32'h4);
    applyStimulus(2'd2, 32'h3);
    readReg(2'd2, rd); checkOutput("div_clamp_3", rd, 32'h4);
    idx = $urandom_range(65535, 4);
    applyStimulus(2'd2, 32'(idx));
    readReg(2'd2, rd); checkOutput("div_rand", rd, 32'(idx));
    applyStimulus(2'd2, 32'(BITLEN));
    applyStimulus(2'd0, {24'b0, 8'($urandom)});
    RXD = 1'b0;
    repeat (30) tick();
    RESET = 1'b1;
    tick();
    checkOutput("mid_rst_txd", 32'(TXD), 32'h1);
    readReg(2'd2, rd); checkOutput("mid_rst_div", rd, RST_DIV);
    RESET = 1'b0;
    RXD = 1'b1;
    mRxQ.delete(); mTxQ.delete();
    mOvr = 1'b0; mFerr = 1'b0; mTxOvf = 1'b0;
    repeat (100) tick();
    checkOutput("post_rst_txd", 32'(TXD), 32'h1);
    readReg(2'd1, rd); checkOutput("post_rst_status", rd, expStatus(1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
